// File: rtl/rf_seq_ctrl_if.sv
// Command and register-file bus of the register-transfer sequencer.
// The master modport is the sequencer's view; slave is the command source / register file side.
interface rf_seq_ctrl_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_dst;
  logic [ADDR_W-1:0] cmd_src_a;
  logic [ADDR_W-1:0] cmd_src_b;
  logic [WIDTH-1:0]  cmd_imm;
  logic [ADDR_W-1:0] rf_rd_addr_a;
  logic [ADDR_W-1:0] rf_rd_addr_b;
  logic [WIDTH-1:0]  rf_d_out_a;
  logic [WIDTH-1:0]  rf_d_out_b;
  logic              rf_wr;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [WIDTH-1:0]  rf_d_in;
  logic              done;
  logic [WIDTH-1:0]  result;
  logic              carry;
  logic              zero;

  modport master (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm,
    input  rf_d_out_a, rf_d_out_b,
    output cmd_ready, rf_rd_addr_a, rf_rd_addr_b, rf_wr, rf_wr_addr, rf_d_in,
    output done, result, carry, zero
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm,
    output rf_d_out_a, rf_d_out_b,
    input  cmd_ready, rf_rd_addr_a, rf_rd_addr_b, rf_wr, rf_wr_addr, rf_d_in,
    input  done, result, carry, zero
  );
endinterface

// File: rtl/rf_seq_ctrl.sv
// Register-transfer sequencer: one command at a time through READ, EXEC and WRITE,
// driving both register-file read ports, a 16-bit ALU and the write-back port.
module rf_seq_ctrl #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic          clk,
  input  logic          reset,
  rf_seq_ctrl_if.master bus
);
  localparam logic [2:0] OP_MOV = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t            state, state_nxt;
  logic              accept;
  logic              ready_c, done_c, wr_c;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] dst_q, src_a_q, src_b_q;
  logic [WIDTH-1:0]  imm_q, opa_q, opb_q;
  logic [WIDTH-1:0]  result_q, d_in_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              carry_q, zero_q;
  logic [WIDTH:0]    alu_res;

  // MSB of the return value is the carry flag, the rest is the result.
  function automatic logic [WIDTH:0] alu(input logic [2:0] op,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b,
                                         input logic [WIDTH-1:0] imm);
    logic [WIDTH:0] r;
    r = '0;
    case (op)
      OP_MOV:  r = {1'b0, a};
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {(a >= b), a - b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_LDI:  r = {1'b0, imm};
      default: r = '0;
    endcase
    return r;
  endfunction

  assign alu_res = alu(op_q, opa_q, opb_q, imm_q);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    done_c    = 1'b0;
    wr_c      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        ready_c = !reset;
        if (bus.cmd_valid && !reset) begin
          accept    = 1'b1;
          state_nxt = READ;
        end
      end
      READ:  state_nxt = EXEC;
      EXEC:  state_nxt = WRITE;
      WRITE: begin
        done_c    = 1'b1;
        wr_c      = (op_q != OP_NOP);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q      <= '0;
      dst_q     <= '0;
      src_a_q   <= '0;
      src_b_q   <= '0;
      imm_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      wr_addr_q <= '0;
      d_in_q    <= '0;
    end else begin
      // IDLE -> READ: command fields captured once, later cmd_* changes are ignored
      if (accept) begin
        op_q    <= bus.cmd_op;
        dst_q   <= bus.cmd_dst;
        src_a_q <= bus.cmd_src_a;
        src_b_q <= bus.cmd_src_b;
        imm_q   <= bus.cmd_imm;
      end
      // READ -> EXEC: operands sampled before any write of this command
      if (state == READ) begin
        opa_q <= bus.rf_d_out_a;
        opb_q <= bus.rf_d_out_b;
      end
      // EXEC -> WRITE: NOP keeps the previous result and flags
      if (state == EXEC) begin
        wr_addr_q <= dst_q;
        if (op_q != OP_NOP) begin
          result_q <= alu_res[WIDTH-1:0];
          carry_q  <= alu_res[WIDTH];
          zero_q   <= (alu_res[WIDTH-1:0] == '0);
          d_in_q   <= alu_res[WIDTH-1:0];
        end else begin
          d_in_q   <= result_q;
        end
      end
    end
  end

  assign bus.cmd_ready    = ready_c;
  assign bus.rf_rd_addr_a = src_a_q;
  assign bus.rf_rd_addr_b = src_b_q;
  assign bus.rf_wr        = wr_c;
  assign bus.rf_wr_addr   = wr_addr_q;
  assign bus.rf_d_in      = d_in_q;
  assign bus.done         = done_c;
  assign bus.result       = result_q;
  assign bus.carry        = carry_q;
  assign bus.zero         = zero_q;
endmodule

// File: tb/tb_rf_seq_ctrl.sv
// Directed bench for rf_seq_ctrl with a resettable 8x16 register file model
// (combinational reads, writes committed at the clock edge).
module tb_rf_seq_ctrl;
  localparam logic [2:0] OP_MOV = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc [3];
  logic [15:0] rf [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rf_seq_ctrl_if #(.WIDTH(16), .ADDR_W(3)) bus ();

  rf_seq_ctrl #(.WIDTH(16), .ADDR_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (bus.rf_wr) begin
      rf[bus.rf_wr_addr] <= bus.rf_d_in;
    end
  end

  assign bus.rf_d_out_a = rf[bus.rf_rd_addr_a];
  assign bus.rf_d_out_b = rf[bus.rf_rd_addr_b];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the sequencer idle; returns at a negedge with it idle again.
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [2:0] dst,
                         input logic [2:0] a, input logic [2:0] b, input logic [15:0] imm,
                         input logic exp_wr, input logic [15:0] exp_res,
                         input logic exp_c, input logic exp_z);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_dst   = dst;
    bus.cmd_src_a = a;
    bus.cmd_src_b = b;
    bus.cmd_imm   = imm;
    #1 chk({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_MOV;
    bus.cmd_dst   = ~dst;
    bus.cmd_src_a = ~a;
    bus.cmd_src_b = ~b;
    bus.cmd_imm   = 16'hDEAD;
    @(negedge clk);
    chk({tag, "_rdaddr_a"}, 32'(bus.rf_rd_addr_a), 32'(a));
    chk({tag, "_done_c1"}, 32'(bus.done), 32'd0);
    @(negedge clk);
    chk({tag, "_done_c2"}, 32'(bus.done), 32'd0);
    @(negedge clk);
    chk({tag, "_done_c3"}, 32'(bus.done), 32'd1);
    chk({tag, "_rf_wr"}, 32'(bus.rf_wr), 32'(exp_wr));
    chk({tag, "_result"}, 32'(bus.result), 32'(exp_res));
    chk({tag, "_carry"}, 32'(bus.carry), 32'(exp_c));
    chk({tag, "_zero"}, 32'(bus.zero), 32'(exp_z));
    if (exp_wr) begin
      chk({tag, "_wr_addr"}, 32'(bus.rf_wr_addr), 32'(dst));
      chk({tag, "_d_in"}, 32'(bus.rf_d_in), 32'(exp_res));
    end
    @(negedge clk);
    chk({tag, "_done_c4"}, 32'(bus.done), 32'd0);
    chk({tag, "_rf_wr_c4"}, 32'(bus.rf_wr), 32'd0);
    if (exp_wr) chk({tag, "_rf"}, 32'(rf[dst]), 32'(exp_res));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_LDI;
    bus.cmd_dst   = 3'd1;
    bus.cmd_src_a = 3'd2;
    bus.cmd_src_b = 3'd3;
    bus.cmd_imm   = 16'h5555;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_rf_wr", 32'(bus.rf_wr), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_carry", 32'(bus.carry), 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd0);
    chk("rst_rdaddr", {26'd0, bus.rf_rd_addr_a, bus.rf_rd_addr_b}, 32'd0);
    chk("rst_wr_addr", 32'(bus.rf_wr_addr), 32'd0);
    chk("rst_d_in", 32'(bus.rf_d_in), 32'd0);
    bus.cmd_valid = 1'b0;
    reset = 1'b0;
    #1 chk("rst_release_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);

    run_cmd("ldi_r1", OP_LDI, 3'd1, 3'd0, 3'd0, 16'h1234, 1'b1, 16'h1234, 1'b0, 1'b0);
    run_cmd("ldi_r2", OP_LDI, 3'd2, 3'd0, 3'd0, 16'h00FF, 1'b1, 16'h00FF, 1'b0, 1'b0);
    run_cmd("add_r3", OP_ADD, 3'd3, 3'd1, 3'd2, 16'h0000, 1'b1, 16'h1333, 1'b0, 1'b0);
    run_cmd("sub_r4", OP_SUB, 3'd4, 3'd2, 3'd1, 16'h0000, 1'b1, 16'hEECB, 1'b0, 1'b0);
    run_cmd("sub_nb", OP_SUB, 3'd0, 3'd1, 3'd2, 16'h0000, 1'b1, 16'h1135, 1'b1, 1'b0);
    run_cmd("ldi_r5", OP_LDI, 3'd5, 3'd0, 3'd0, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    run_cmd("ldi_r6", OP_LDI, 3'd6, 3'd0, 3'd0, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b0);
    run_cmd("add_r7", OP_ADD, 3'd7, 3'd5, 3'd6, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1);

    // cmd_valid held high across three dependent commands
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_LDI;
    bus.cmd_dst   = 3'd1;
    bus.cmd_src_a = 3'd0;
    bus.cmd_src_b = 3'd0;
    bus.cmd_imm   = 16'h0005;
    for (int k = 0; k < 3; k++) begin
      int w;
      w = 0;
      while (!bus.cmd_ready && w < 12) begin
        @(negedge clk);
        w++;
      end
      chk("b2b_wait_ready", 32'(bus.cmd_ready), 32'd1);
      acc[k] = cyc;
      @(posedge clk);
      #1;
      if (k < 2) begin
        bus.cmd_op    = OP_ADD;
        bus.cmd_src_a = 3'd1;
        bus.cmd_src_b = 3'd1;
        bus.cmd_imm   = 16'h0000;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b_gap1", 32'(acc[1] - acc[0]), 32'd4);
    chk("b2b_gap2", 32'(acc[2] - acc[1]), 32'd4);
    repeat (4) @(negedge clk);
    chk("b2b_r1", 32'(rf[1]), 32'h0014);
    chk("b2b_result", 32'(bus.result), 32'h0014);

    run_cmd("ldi_f0", OP_LDI, 3'd1, 3'd0, 3'd0, 16'hF0F0, 1'b1, 16'hF0F0, 1'b0, 1'b0);
    run_cmd("ldi_0f", OP_LDI, 3'd2, 3'd0, 3'd0, 16'h0FF0, 1'b1, 16'h0FF0, 1'b0, 1'b0);
    run_cmd("add_c",  OP_ADD, 3'd0, 3'd5, 3'd6, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1);
    run_cmd("and",    OP_AND, 3'd4, 3'd1, 3'd2, 16'h0000, 1'b1, 16'h00F0, 1'b0, 1'b0);
    run_cmd("or",     OP_OR,  3'd5, 3'd1, 3'd2, 16'h0000, 1'b1, 16'hFFF0, 1'b0, 1'b0);
    run_cmd("xor",    OP_XOR, 3'd6, 3'd1, 3'd2, 16'h0000, 1'b1, 16'hFF00, 1'b0, 1'b0);
    run_cmd("mov",    OP_MOV, 3'd3, 3'd1, 3'd2, 16'h0000, 1'b1, 16'hF0F0, 1'b0, 1'b0);
    run_cmd("self",   OP_XOR, 3'd1, 3'd1, 3'd1, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1);
    run_cmd("ldi_ff", OP_LDI, 3'd5, 3'd0, 3'd0, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    run_cmd("ldi_01", OP_LDI, 3'd6, 3'd0, 3'd0, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b0);
    run_cmd("add_cy", OP_ADD, 3'd7, 3'd5, 3'd6, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1);
    run_cmd("nop",    OP_NOP, 3'd3, 3'd5, 3'd6, 16'h1111, 1'b0, 16'h0000, 1'b1, 1'b1);
    chk("nop_r3_kept", 32'(rf[3]), 32'h0000F0F0);

    // reset arriving in the EXEC cycle aborts the pending LDI
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_LDI;
    bus.cmd_dst   = 3'd2;
    bus.cmd_imm   = 16'hAAAA;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_exec_done", 32'(bus.done), 32'd0);
    reset = 1'b1;
    #1 chk("abort_ready_rst", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    chk("abort_rf_wr", 32'(bus.rf_wr), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_ready_hold", 32'(bus.cmd_ready), 32'd0);
    chk("abort_carry", 32'(bus.carry), 32'd0);
    @(negedge clk);
    chk("abort_rf_wr2", 32'(bus.rf_wr), 32'd0);
    chk("abort_r2", 32'(rf[2]), 32'd0);
    reset = 1'b0;
    #1 chk("abort_ready_back", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    chk("abort_done_after", 32'(bus.done), 32'd0);
    chk("abort_rf_wr_after", 32'(bus.rf_wr), 32'd0);
    chk("abort_r2_after", 32'(rf[2]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
